// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: pops bytes from an upstream synchronous FIFO and shifts them out as
// async serial frames (start, 8 data LSB first, stop). Define TX_SERIALIZER_PARITY_EN for even parity.
module fifo_tx_serializer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd,
    output logic       txd,
    output logic       busy
);

    localparam int            TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef TX_SERIALIZER_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            w_bit_done;
    logic            w_timed;
    logic            w_start_ok;
`ifdef TX_SERIALIZER_PARITY_EN
    logic            r_parity;
`endif

    assign w_bit_done = (r_timer == LAST_TICK);
    assign w_start_ok = tx_en && !fifo_empty;
    assign w_timed    = (r_state != S_IDLE) && (r_state != S_FETCH) && (r_state != S_LOAD);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state is defaulted first so no path through the case infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next_state = S_FETCH;
            S_FETCH: w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_START;
            S_START: if (w_bit_done) w_next_state = S_DATA;
            S_DATA: begin
                if (w_bit_done && (r_bit_idx == 3'd7)) begin
`ifdef TX_SERIALIZER_PARITY_EN
                    w_next_state = S_PARITY;
`else
                    w_next_state = S_STOP;
`endif
                end
            end
`ifdef TX_SERIALIZER_PARITY_EN
            S_PARITY: if (w_bit_done) w_next_state = S_STOP;
`endif
            S_STOP: begin
                if (w_bit_done) w_next_state = w_start_ok ? S_FETCH : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Every timed state is left only when the bit ends, so clearing on bit end also
    // clears on entry; untimed states hold the timer at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (!w_timed || w_bit_done) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // NOTE: the byte datapath is reset too, so a frame aborted by reset leaves nothing stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
`ifdef TX_SERIALIZER_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (r_state == S_LOAD) begin
            r_shift   <= fifo_dout;
            r_bit_idx <= '0;
`ifdef TX_SERIALIZER_PARITY_EN
            r_parity  <= ^fifo_dout;
`endif
        end else if ((r_state == S_DATA) && w_bit_done) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        txd = 1'b1;
        case (r_state)
            S_START:  txd = 1'b0;
            S_DATA:   txd = r_shift[0];
`ifdef TX_SERIALIZER_PARITY_EN
            S_PARITY: txd = r_parity;
`endif
            default:  txd = 1'b1;
        endcase
    end

    assign fifo_rd = (r_state == S_FETCH);
    assign busy    = (r_state != S_IDLE);

endmodule
